// File: rtl/unidade_busca.sv
// Fetch stage: program counter, next-PC selection, return-address stack and
// run/halt control for the single-cycle processor.
module unidade_busca #(
  parameter int LARGURA_END        = 8,
  parameter int PROFUNDIDADE_PILHA = 4,
  parameter logic [LARGURA_END-1:0] ENDERECO_INICIAL = '0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Stall,
  input  logic                   Desvio,
  input  logic [LARGURA_END-1:0] DeslocDesvio,
  input  logic                   Salto,
  input  logic [LARGURA_END-1:0] AlvoSalto,
  input  logic                   Chamada,
  input  logic                   Retorno,
  input  logic                   Parar,
  input  logic                   Retomar,
  output logic [LARGURA_END-1:0] Endereco,
  output logic [LARGURA_END-1:0] PCMais1,
  output logic                   Valido,
  output logic                   PilhaVazia,
  output logic                   PilhaCheia,
  output logic                   ErroPilha,
  output logic [1:0]             estado_dbg
);

  localparam int PW = $clog2(PROFUNDIDADE_PILHA);
  localparam logic [PW:0] SP_CHEIO = (PW+1)'(PROFUNDIDADE_PILHA);

  typedef enum logic [1:0] {
    INICIO  = 2'd0,
    EXECUTA = 2'd1,
    PARADO  = 2'd2
  } estado_t;

  estado_t                estado, estado_prox;
  logic [LARGURA_END-1:0] pc, pc_prox, pc_mais1;
  logic [PW:0]            sp, sp_prox, sp_menos1;
  logic                   erro, erro_prox;
  logic                   empilha;
  logic [LARGURA_END-1:0] topo;
  logic [LARGURA_END-1:0] pilha [PROFUNDIDADE_PILHA];

  assign pc_mais1  = pc + LARGURA_END'(1);
  assign sp_menos1 = sp - (PW+1)'(1);
  assign topo      = pilha[sp_menos1[PW-1:0]];

  // State register; stack contents are not reset (don't-care until pushed).
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      estado <= INICIO;
      pc     <= ENDERECO_INICIAL;
      sp     <= '0;
      erro   <= 1'b0;
    end else begin
      estado <= estado_prox;
      pc     <= pc_prox;
      sp     <= sp_prox;
      erro   <= erro_prox;
    end
  end

  always_ff @(posedge Clock) begin
    if (empilha) pilha[sp[PW-1:0]] <= pc_mais1;
  end

  // Request priority in EXECUTA, highest first: Parar, Stall, Retorno,
  // Chamada, Salto, Desvio, sequential. Each request is a one-cycle level
  // sampled on the rising edge; there is no handshake back to decode.
  always_comb begin
    estado_prox = estado;
    pc_prox     = pc;
    sp_prox     = sp;
    erro_prox   = erro;
    empilha     = 1'b0;
    unique case (estado)
      INICIO: estado_prox = EXECUTA;
      EXECUTA: begin
        if (Parar) begin
          estado_prox = PARADO;
        end else if (Stall) begin
          pc_prox = pc;
        end else if (Retorno) begin
          if (sp != '0) begin
            pc_prox = topo;
            sp_prox = sp_menos1;
          end else begin
            erro_prox   = 1'b1;
            estado_prox = PARADO;
          end
        end else if (Chamada) begin
          if (sp != SP_CHEIO) begin
            empilha = 1'b1;
            sp_prox = sp + (PW+1)'(1);
            pc_prox = AlvoSalto;
          end else begin
            erro_prox   = 1'b1;
            estado_prox = PARADO;
          end
        end else if (Salto) begin
          pc_prox = AlvoSalto;
        end else if (Desvio) begin
          // Equal-width add wraps modulo 2^LARGURA_END, so the offset's
          // two's-complement sign needs no explicit extension.
          pc_prox = pc + DeslocDesvio;
        end else begin
          pc_prox = pc_mais1;
        end
      end
      PARADO: begin
        if (Retomar && !erro) estado_prox = EXECUTA;
      end
      default: estado_prox = INICIO;
    endcase
  end

  always_comb begin
    Valido     = (estado == EXECUTA);
    Endereco   = pc;
    PCMais1    = pc_mais1;
    PilhaVazia = (sp == '0);
    PilhaCheia = (sp == SP_CHEIO);
    ErroPilha  = erro;
    estado_dbg = estado;
  end

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: queue-based reference model compared every cycle,
// plus directed scenarios with literal expected addresses and flags.
module tb_unidade_busca;

  logic       Clock, Reset;
  logic       Stall, Desvio, Salto, Chamada, Retorno, Parar, Retomar;
  logic [7:0] DeslocDesvio, AlvoSalto;
  logic [7:0] Endereco, PCMais1;
  logic       Valido, PilhaVazia, PilhaCheia, ErroPilha;
  logic [1:0] estado_dbg;

  int checks   = 0;
  int failures = 0;

  unidade_busca #(.LARGURA_END(8), .PROFUNDIDADE_PILHA(4), .ENDERECO_INICIAL(8'd0)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Desvio(Desvio),
    .DeslocDesvio(DeslocDesvio), .Salto(Salto), .AlvoSalto(AlvoSalto),
    .Chamada(Chamada), .Retorno(Retorno), .Parar(Parar), .Retomar(Retomar),
    .Endereco(Endereco), .PCMais1(PCMais1), .Valido(Valido),
    .PilhaVazia(PilhaVazia), .PilhaCheia(PilhaCheia), .ErroPilha(ErroPilha),
    .estado_dbg(estado_dbg)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: PC as an integer, stack as a queue, mode as a word.
  localparam int M_INI = 0, M_RUN = 1, M_HALT = 2;
  int m_pc   = 0;
  int m_mode = M_INI;
  bit m_err  = 0;
  bit m_ok   = 0;
  int m_q[$];

  initial begin
    forever begin
      @(posedge Clock or posedge Reset);
      if (Reset) begin
        m_pc = 0; m_mode = M_INI; m_err = 0; m_q.delete(); m_ok = 1;
      end else if (m_mode == M_INI) begin
        m_mode = M_RUN;
      end else if (m_mode == M_HALT) begin
        if (Retomar && !m_err) m_mode = M_RUN;
      end else if (Parar) begin
        m_mode = M_HALT;
      end else if (Stall) begin
        m_pc = m_pc;
      end else if (Retorno) begin
        if (m_q.size() > 0) m_pc = m_q.pop_back();
        else begin m_err = 1; m_mode = M_HALT; end
      end else if (Chamada) begin
        if (m_q.size() < 4) begin m_q.push_back((m_pc + 1) % 256); m_pc = int'(AlvoSalto); end
        else begin m_err = 1; m_mode = M_HALT; end
      end else if (Salto) begin
        m_pc = int'(AlvoSalto);
      end else if (Desvio) begin
        m_pc = (m_pc + int'($signed(DeslocDesvio)) + 256) % 256;
      end else begin
        m_pc = (m_pc + 1) % 256;
      end
    end
  end

  // Scoreboard compare, away from the active edge
  always @(negedge Clock) begin
    if (m_ok) begin
      check("endereco", 32'(Endereco), 32'(m_pc));
      check("pcmais1", 32'(PCMais1), 32'((m_pc + 1) % 256));
      check("valido", 32'(Valido), 32'(m_mode == M_RUN));
      check("pilha_vazia", 32'(PilhaVazia), 32'(m_q.size() == 0));
      check("pilha_cheia", 32'(PilhaCheia), 32'(m_q.size() == 4));
      check("erro_pilha", 32'(ErroPilha), 32'(m_err));
    end
  end

  // Driver tasks: inputs change 1 time unit after a rising edge.
  task automatic clr();
    Stall = 0; Desvio = 0; Salto = 0; Chamada = 0; Retorno = 0;
    Parar = 0; Retomar = 0; DeslocDesvio = '0; AlvoSalto = '0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    clr();
  endtask

  task automatic jump(input logic [7:0] alvo);
    Salto = 1; AlvoSalto = alvo; step();
  endtask

  task automatic do_reset();
    Reset = 1;
    @(posedge Clock);
    #1 Reset = 0;
  endtask

  initial begin
    Reset = 1;
    clr();
    repeat (2) @(posedge Clock);
    #1 Reset = 0;

    // Free run with wrap
    check("ini_endereco", 32'(Endereco), 32'd0);
    check("ini_valido", 32'(Valido), 32'd0);
    step();
    check("run_valido", 32'(Valido), 32'd1);
    check("run_endereco0", 32'(Endereco), 32'd0);
    for (int k = 1; k <= 256; k++) begin
      step();
      check("seq_endereco", 32'(Endereco), 32'(k % 256));
    end

    // Branches, negative offset and wrap-around
    repeat (10) step();
    check("pc10", 32'(Endereco), 32'd10);
    Desvio = 1; DeslocDesvio = 8'hFB; step();
    check("desvio_neg", 32'(Endereco), 32'd5);
    jump(8'd250);
    check("salto250", 32'(Endereco), 32'd250);
    Desvio = 1; DeslocDesvio = 8'd10; step();
    check("desvio_wrap", 32'(Endereco), 32'd4);

    // Call / return
    jump(8'd3);
    Chamada = 1; AlvoSalto = 8'd40; step();
    check("call_end", 32'(Endereco), 32'd40);
    check("call_vazia", 32'(PilhaVazia), 32'd0);
    step(); step();
    check("call_42", 32'(Endereco), 32'd42);
    Retorno = 1; Chamada = 1; AlvoSalto = 8'd77; step();
    check("ret_end", 32'(Endereco), 32'd4);
    check("ret_vazia", 32'(PilhaVazia), 32'd1);

    // Nested calls to full, then overflow
    for (int i = 0; i < 4; i++) begin
      Chamada = 1; AlvoSalto = 8'(100 + 10 * i); step();
    end
    check("nest_cheia", 32'(PilhaCheia), 32'd1);
    check("nest_end", 32'(Endereco), 32'd130);
    Chamada = 1; AlvoSalto = 8'd200; step();
    check("ovf_erro", 32'(ErroPilha), 32'd1);
    check("ovf_valido", 32'(Valido), 32'd0);
    check("ovf_end", 32'(Endereco), 32'd130);
    Retomar = 1; step();
    check("ovf_retomar_valido", 32'(Valido), 32'd0);
    check("ovf_retomar_end", 32'(Endereco), 32'd130);
    Reset = 1; #1;
    check("rst_erro", 32'(ErroPilha), 32'd0);
    check("rst_cheia", 32'(PilhaCheia), 32'd0);
    check("rst_vazia", 32'(PilhaVazia), 32'd1);
    check("rst_end", 32'(Endereco), 32'd0);
    @(posedge Clock);
    #1 Reset = 0;
    step();

    // Underflow on empty stack
    Retorno = 1; step();
    check("udf_erro", 32'(ErroPilha), 32'd1);
    check("udf_valido", 32'(Valido), 32'd0);
    do_reset();
    step();

    // Halt and resume
    jump(8'd7);
    Parar = 1; step();
    check("halt_valido", 32'(Valido), 32'd0);
    check("halt_end", 32'(Endereco), 32'd7);
    for (int i = 0; i < 5; i++) begin
      Salto = 1; AlvoSalto = 8'd99; step();
      check("halt_hold", 32'(Endereco), 32'd7);
    end
    Retomar = 1; step();
    check("resume_valido", 32'(Valido), 32'd1);
    check("resume_end", 32'(Endereco), 32'd7);
    step();
    check("resume_next", 32'(Endereco), 32'd8);

    // Stall
    jump(8'd20);
    for (int i = 0; i < 3; i++) begin
      Stall = 1; Desvio = 1; DeslocDesvio = 8'd5; step();
      check("stall_hold", 32'(Endereco), 32'd20);
    end
    step();
    check("stall_release", 32'(Endereco), 32'd21);

    // Asynchronous reset between edges after a call
    jump(8'd60);
    Chamada = 1; AlvoSalto = 8'd90; step();
    check("acall_end", 32'(Endereco), 32'd90);
    check("acall_vazia", 32'(PilhaVazia), 32'd0);
    #2 Reset = 1;
    #1;
    check("arst_end", 32'(Endereco), 32'd0);
    check("arst_vazia", 32'(PilhaVazia), 32'd1);
    @(posedge Clock);
    #1 Reset = 0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unidade_busca.md
Name: unidade_busca

Overview:
Fetch stage of the single-cycle processor. Holds the program counter and drives the instruction memory address bus (Endereco, 8 bits, one address per Clock). Computes the next PC from sequential, branch, jump, call and return requests coming back from decode/execute. Keeps a small return-address stack and a run/halt state machine.

Parameters:
LARGURA_END, 8, width of PC, Endereco and all address/offset ports
PROFUNDIDADE_PILHA, 4, number of return-address stack entries (power of two, at least 2)
ENDERECO_INICIAL, 0, PC value loaded on reset

Ports:
Clock  input  1  system clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
Stall  input  1  hold PC and stack this cycle
Desvio  input  1  conditional branch taken
DeslocDesvio  input  LARGURA_END  signed two's-complement branch offset, relative to current PC
Salto  input  1  absolute jump request
AlvoSalto  input  LARGURA_END  jump target; also the call target
Chamada  input  1  call request: push PC+1, jump to AlvoSalto
Retorno  input  1  return request: pop PC from stack
Parar  input  1  enter halt state
Retomar  input  1  leave halt state
Endereco  output  LARGURA_END  current PC, wired to instruction memory address
PCMais1  output  LARGURA_END  Endereco+1 mod 2^LARGURA_END, combinational
Valido  output  1  current Endereco is a live fetch
PilhaVazia  output  1  stack has 0 entries
PilhaCheia  output  1  stack has PROFUNDIDADE_PILHA entries
ErroPilha  output  1  sticky flag for stack overflow or underflow

Behaviour:
- Reset (async, any time, including mid-call or mid-halt):
  - PC=ENDERECO_INICIAL; state=INICIO; stack pointer=0.
  - Valido=0, PilhaVazia=1, PilhaCheia=0, ErroPilha=0.
  - Stack contents are don't-care.
- States:
  - INICIO: one cycle, Valido=0, PC holds. Then goes unconditionally to EXECUTA.
  - EXECUTA: Valido=1.
  - PARADO: Valido=0, PC and stack hold.
- EXECUTA: next PC on the rising edge, first matching rule wins:
  1. Parar: go to PARADO; PC holds.
  2. Stall: PC and stack hold.
  3. Retorno:
     - stack not empty: PC=top entry; pop.
     - stack empty: ErroPilha=1, go to PARADO, PC holds.
  4. Chamada:
     - stack not full: push PCMais1; PC=AlvoSalto.
     - stack full: ErroPilha=1, go to PARADO, PC and stack unchanged.
  5. Salto: PC=AlvoSalto.
  6. Desvio: PC=PC+DeslocDesvio, mod 2^LARGURA_END (offset sign-extended, result wraps).
  7. Otherwise: PC=PCMais1. 8'hFF wraps to 8'h00.
- Latency: a request sampled at edge N is visible on Endereco immediately after edge N. No delay slot.
- PARADO:
  - Retomar with ErroPilha=0: go to EXECUTA; PC continues from the held value.
  - Retomar with ErroPilha=1: ignored. Only Reset leaves PARADO.
  - All other control inputs are ignored.
- INICIO: all control inputs are ignored.
- Stack:
  - LIFO; push writes entry[sp] then sp=sp+1; pop reads entry[sp-1] then sp=sp-1.
  - PilhaVazia = (sp==0); PilhaCheia = (sp==PROFUNDIDADE_PILHA). Both derive from registered sp.
- ErroPilha: set only by overflow or underflow; cleared only by Reset.
- Simultaneous Chamada+Retorno: Retorno wins and the call is dropped.

Test Plan:
- Reset then free-run, no requests -> cycle 1 Endereco=0, Valido=0; then Valido=1 and Endereco steps 0,1,2,...,255,0 (wrap checked at 8'hFF->8'h00).
- At PC=10, Desvio with DeslocDesvio=8'hFB -> next Endereco=5; at PC=250, DeslocDesvio=10 -> next Endereco=4.
- At PC=3, Chamada with AlvoSalto=40 -> Endereco=40, PilhaVazia=0; two idle cycles reach PC 42; Retorno -> Endereco=4, PilhaVazia=1.
- Four nested Chamada calls -> PilhaCheia=1; fifth Chamada -> ErroPilha=1, Valido=0, PC held; Retomar has no effect; Reset clears all flags.
- At PC=7, Parar -> Valido=0 and PC=7 held for 5 cycles despite Salto; Retomar -> Valido=1, next Endereco=8. Stall at PC=20 for 3 cycles -> Endereco holds 20.
- Assert Reset asynchronously between edges during a call at PC=60 -> Endereco=0 and PilhaVazia=1 immediately, without waiting for a clock edge.
